// File: rtl/ahbl_excl_sram_responder.sv
// AHB-Lite responder backed by an internal RAM, with configurable wait states,
// two-cycle ERROR responses and a single-reservation exclusive monitor.
module ahbl_excl_sram_responder #(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned W_DATA = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned N_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    output logic              ahbls_hexokay,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic              ahbls_hexcl,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata
);

    localparam int unsigned W_WORD  = $clog2(DEPTH);
    localparam int unsigned W_BADDR = W_WORD + 2;
    localparam int unsigned N_BYTE  = W_DATA / 8;
    localparam int unsigned W_CNT   = 4;
    localparam logic [W_ADDR:0] ADDR_LIMIT = (W_ADDR + 1)'(DEPTH * 4);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t               state_q, state_d;
    logic [W_CNT-1:0]     cnt_q, cnt_d;
    logic                 dph_q, dph_d;
    logic [W_BADDR-1:0]   addr_q, addr_d;
    logic                 write_q, write_d;
    logic [1:0]           size_q, size_d;
    logic                 excl_q, excl_d;
    logic                 resv_v_q, resv_v_d;
    logic [W_WORD-1:0]    resv_a_q, resv_a_d;
    logic                 hready_d, hresp_d, hexokay_d, final_d;
    logic [W_DATA-1:0]    hrdata_d;

    logic                 final_c, accept_c, err_c, resv_hit_c, we_c;
    logic [W_WORD-1:0]    word_c, word_d_c;
    logic [N_BYTE-1:0]    strb_c;
    logic [W_DATA-1:0]    rdata_fwd_c;
    logic                 unused_c;

    logic [W_DATA-1:0]    mem [DEPTH];

    assign unused_c = ^{ahbls_htrans[0], ahbls_hburst, ahbls_hprot, ahbls_hmastlock};

    // Current data phase: commit conditions and byte strobes
    always_comb begin
        final_c    = dph_q && (state_q == ST_IDLE);
        word_c     = addr_q[W_BADDR-1:2];
        resv_hit_c = resv_v_q && (resv_a_q == word_c);
        we_c       = final_c && write_q && (!excl_q || resv_hit_c);
        case (size_q)
            2'd0:    strb_c = N_BYTE'(1) << addr_q[1:0];
            2'd1:    strb_c = addr_q[1] ? N_BYTE'(4'b1100) : N_BYTE'(4'b0011);
            default: strb_c = '1;
        endcase
    end

    // Address-phase acceptance and error classification
    always_comb begin
        accept_c = ahbls_hready && ahbls_htrans[1] &&
                   ((state_q == ST_IDLE) || (state_q == ST_ERR2));
        err_c    = ({1'b0, ahbls_haddr} >= ADDR_LIMIT) ||
                   (ahbls_hsize > 3'd2) ||
                   ((ahbls_hsize == 3'd1) && ahbls_haddr[0]) ||
                   ((ahbls_hsize == 3'd2) && (ahbls_haddr[1:0] != 2'b00));
    end

    // Reservation update at the end of a final OKAY cycle
    always_comb begin
        resv_v_d = resv_v_q;
        resv_a_d = resv_a_q;
        if (final_c) begin
            if (!write_q && excl_q) begin
                resv_v_d = 1'b1;
                resv_a_d = word_c;
            end else if (write_q && (excl_q || resv_hit_c)) begin
                resv_v_d = 1'b0;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dph_d    = dph_q;
        addr_d   = addr_q;
        write_d  = write_q;
        size_d   = size_q;
        excl_d   = excl_q;
        hready_d = 1'b1;
        hresp_d  = 1'b0;
        final_d  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    final_d = 1'b1;
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    hready_d = 1'b0;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
                hresp_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                dph_d   = 1'b0;
                if (accept_c) begin
                    addr_d  = ahbls_haddr[W_BADDR-1:0];
                    write_d = ahbls_hwrite;
                    size_d  = ahbls_hsize[1:0];
                    excl_d  = ahbls_hexcl;
                    if (err_c) begin
                        state_d  = ST_ERR1;
                        hready_d = 1'b0;
                        hresp_d  = 1'b1;
                    end else begin
                        dph_d = 1'b1;
                        if (N_WAIT != 0) begin
                            state_d  = ST_WAIT;
                            cnt_d    = W_CNT'(N_WAIT - 1);
                            hready_d = 1'b0;
                        end else begin
                            final_d = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    // Registered response for the coming final cycle; forwards a same-edge write
    always_comb begin
        word_d_c    = addr_d[W_BADDR-1:2];
        rdata_fwd_c = mem[word_d_c];
        if (we_c && (word_c == word_d_c)) begin
            for (int unsigned b = 0; b < N_BYTE; b++) begin
                if (strb_c[b]) begin
                    rdata_fwd_c[8*b +: 8] = ahbls_hwdata[8*b +: 8];
                end
            end
        end
        hexokay_d = final_d && excl_d &&
                    (!write_d || (resv_v_d && (resv_a_d == word_d_c)));
        hrdata_d  = (final_d && !write_d) ? rdata_fwd_c : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            dph_q             <= 1'b0;
            addr_q            <= '0;
            write_q           <= 1'b0;
            size_q            <= '0;
            excl_q            <= 1'b0;
            resv_v_q          <= 1'b0;
            resv_a_q          <= '0;
            ahbls_hready_resp <= 1'b1;
            ahbls_hresp       <= 1'b0;
            ahbls_hexokay     <= 1'b0;
            ahbls_hrdata      <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            dph_q             <= dph_d;
            addr_q            <= addr_d;
            write_q           <= write_d;
            size_q            <= size_d;
            excl_q            <= excl_d;
            resv_v_q          <= resv_v_d;
            resv_a_q          <= resv_a_d;
            ahbls_hready_resp <= hready_d;
            ahbls_hresp       <= hresp_d;
            ahbls_hexokay     <= hexokay_d;
            ahbls_hrdata      <= hrdata_d;
        end
    end

    // RAM contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (we_c) begin
            for (int unsigned b = 0; b < N_BYTE; b++) begin
                if (strb_c[b]) begin
                    mem[word_c][8*b +: 8] <= ahbls_hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahbl_excl_sram_responder.sv
// Bench for ahbl_excl_sram_responder: one instance with no wait states, one with two,
// driven by a pipelined AHB-Lite manager and checked against a word-array model.
module tb_ahbl_excl_sram_responder;

    localparam int unsigned DEPTH = 256;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] haddr, hwdata;
    logic        hwrite, hexcl, hmastlock;
    logic [1:0]  htrans, htrans0, htrans2;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        rdy0, resp0, exok0, rdy2, resp2, exok2;
    logic [31:0] rdata0, rdata2;
    int          sel;
    logic        rdy_o, resp_o, exok_o;
    logic [31:0] rdata_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m [2][DEPTH];
    bit          rv [2];
    int unsigned ra [2];
    int          nwait [2] = '{0, 2};

    bit          pend_v, pend_w, pend_x;
    logic [31:0] pend_a, pend_d;
    logic [2:0]  pend_s;

    always #5 clk = ~clk;

    assign htrans0 = (sel == 0) ? htrans : T_IDLE;
    assign htrans2 = (sel == 1) ? htrans : T_IDLE;
    assign rdy_o   = (sel == 1) ? rdy2   : rdy0;
    assign resp_o  = (sel == 1) ? resp2  : resp0;
    assign exok_o  = (sel == 1) ? exok2  : exok0;
    assign rdata_o = (sel == 1) ? rdata2 : rdata0;

    ahbl_excl_sram_responder #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH), .N_WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .ahbls_hready(rdy0), .ahbls_hready_resp(rdy0), .ahbls_hresp(resp0),
        .ahbls_hexokay(exok0), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite),
        .ahbls_htrans(htrans0), .ahbls_hsize(hsize), .ahbls_hburst(hburst),
        .ahbls_hprot(hprot), .ahbls_hmastlock(hmastlock), .ahbls_hexcl(hexcl),
        .ahbls_hwdata(hwdata), .ahbls_hrdata(rdata0)
    );

    ahbl_excl_sram_responder #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH), .N_WAIT(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .ahbls_hready(rdy2), .ahbls_hready_resp(rdy2), .ahbls_hresp(resp2),
        .ahbls_hexokay(exok2), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite),
        .ahbls_htrans(htrans2), .ahbls_hsize(hsize), .ahbls_hburst(hburst),
        .ahbls_hprot(hprot), .ahbls_hmastlock(hmastlock), .ahbls_hexcl(hexcl),
        .ahbls_hwdata(hwdata), .ahbls_hrdata(rdata2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut=%0d observed=%h expected=%h", tag, sel, obs, exp);
        end
    endtask

    task automatic chk_rst_outs(input string tag);
        chk({tag, "_hready"}, 32'(rdy_o), 32'd1);
        chk({tag, "_hresp"}, 32'(resp_o), 32'd0);
        chk({tag, "_hexokay"}, 32'(exok_o), 32'd0);
        chk({tag, "_hrdata"}, rdata_o, 32'd0);
    endtask

    function automatic bit model_err(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b1;
        if (a >= DEPTH * 4) return 1'b1;
        return (a % (32'd1 << s)) != 0;
    endfunction

    // Present one address phase while completing (and checking) the previous data phase
    task automatic step(input logic [1:0] tr, input bit w, input bit x,
                        input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        bit          perr, done, exok_e;
        int          lows, ew;
        int unsigned wd, lo, n;
        logic [31:0] rd_e, tmp;
        htrans = tr; hwrite = w; hexcl = x; haddr = a; hsize = s; hwdata = pend_d;
        hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
        perr   = pend_v && model_err(pend_a, pend_s);
        ew     = !pend_v ? 0 : (perr ? 1 : nwait[sel]);
        wd     = (pend_a / 4) % DEPTH;
        exok_e = 1'b0;
        rd_e   = 32'd0;
        if (pend_v && !perr) begin
            if (!pend_w) begin
                rd_e   = mem_m[sel][wd];
                exok_e = pend_x;
            end else begin
                exok_e = pend_x && rv[sel] && (ra[sel] == wd);
            end
        end
        lows = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (rdy_o === 1'b1) begin
                done = 1'b1;
            end else begin
                chk("dph_hresp", 32'(resp_o), 32'(perr));
                chk("dph_hexokay", 32'(exok_o), 32'd0);
                chk("dph_hrdata", rdata_o, 32'd0);
                lows++;
                @(posedge clk); #1;
            end
        end
        chk("hready_seen", 32'(done), 32'd1);
        chk("wait_cycles", 32'(lows), 32'(ew));
        chk("final_hresp", 32'(resp_o), 32'(perr));
        chk("final_hexokay", 32'(exok_o), 32'(exok_e));
        chk("final_hrdata", rdata_o, rd_e);
        @(posedge clk); #1;
        if (pend_v && !perr) begin
            if (pend_w && (!pend_x || exok_e)) begin
                lo  = pend_a % 4;
                n   = 1 << pend_s;
                tmp = mem_m[sel][wd];
                for (int b = 0; b < 4; b++) begin
                    if (b >= lo && b < lo + n) tmp[8*b +: 8] = pend_d[8*b +: 8];
                end
                mem_m[sel][wd] = tmp;
            end
            if (!pend_w && pend_x) begin
                rv[sel] = 1'b1;
                ra[sel] = wd;
            end else if (pend_w && (pend_x || (rv[sel] && ra[sel] == wd))) begin
                rv[sel] = 1'b0;
            end
        end
        pend_v = tr[1]; pend_w = w; pend_x = x; pend_a = a; pend_s = s; pend_d = d;
    endtask

    task automatic idle_step();
        step(T_IDLE, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    endtask

    task automatic fill_ram();
        for (int i = 0; i < DEPTH; i++) begin
            step(T_NSEQ, 1'b1, 1'b0, 32'(i * 4), 3'd2, $urandom);
        end
        idle_step();
    endtask

    task automatic excl_plan();
        step(T_NSEQ, 1'b0, 1'b1, 32'h20, 3'd2, 32'd0);
        step(T_NSEQ, 1'b1, 1'b1, 32'h20, 3'd2, 32'h0000_1234);
        step(T_NSEQ, 1'b1, 1'b1, 32'h20, 3'd2, 32'h0000_5678);
        step(T_NSEQ, 1'b0, 1'b0, 32'h20, 3'd2, 32'd0);
        step(T_NSEQ, 1'b0, 1'b1, 32'h20, 3'd2, 32'd0);
        step(T_NSEQ, 1'b1, 1'b0, 32'h20, 3'd2, 32'hCAFE_0001);
        step(T_NSEQ, 1'b1, 1'b1, 32'h20, 3'd2, 32'hCAFE_0002);
        step(T_NSEQ, 1'b0, 1'b0, 32'h20, 3'd2, 32'd0);
        // an error between reservation and exclusive write leaves the reservation alone
        step(T_NSEQ, 1'b0, 1'b1, 32'h24, 3'd2, 32'd0);
        step(T_NSEQ, 1'b1, 1'b1, 32'h400, 3'd2, 32'hBAD0_BAD0);
        step(T_NSEQ, 1'b1, 1'b1, 32'h24, 3'd1, 32'h7777_7777);
        step(T_NSEQ, 1'b0, 1'b0, 32'h24, 3'd2, 32'd0);
        // exclusive write to a different word than the reservation fails
        step(T_NSEQ, 1'b0, 1'b1, 32'h28, 3'd2, 32'd0);
        step(T_NSEQ, 1'b1, 1'b1, 32'h2C, 3'd2, 32'h1111_2222);
        step(T_NSEQ, 1'b0, 1'b0, 32'h2C, 3'd2, 32'd0);
        idle_step();
    endtask

    task automatic rand_run(input int n);
        logic [1:0]  tr;
        logic [31:0] a;
        logic [2:0]  s;
        int          r, k;
        for (int i = 0; i < n; i++) begin
            r  = $urandom_range(0, 9);
            tr = (r == 0) ? T_IDLE : (r == 1) ? T_BUSY : (r < 6) ? T_NSEQ : T_SEQ;
            k  = $urandom_range(0, 9);
            if (k < 6)       a = 32'h20 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            else if (k < 8)  a = 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            else if (k == 8) a = 32'h3FC + 32'($urandom_range(0, 3));
            else             a = ($urandom_range(0, 1) == 0) ? 32'h400 + 32'($urandom_range(0, 255)) : $urandom;
            s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if (s <= 3'd2 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << s) - 32'd1);
            step(tr, 1'($urandom), 1'($urandom), a, s, $urandom);
        end
        idle_step();
    endtask

    initial begin
        rst = 1'b1; sel = 0;
        htrans = T_IDLE; hwrite = 1'b0; hexcl = 1'b0; haddr = '0; hsize = '0;
        hburst = '0; hprot = '0; hmastlock = 1'b0; hwdata = '0;
        pend_v = 1'b0; pend_w = 1'b0; pend_x = 1'b0; pend_a = '0; pend_s = '0; pend_d = '0;
        rv = '{1'b0, 1'b0}; ra = '{0, 0};
        repeat (2) @(posedge clk);
        #1 sel = 0;
        #1 chk_rst_outs("reset0");
        sel = 1;
        #1 chk_rst_outs("reset2");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // zero-wait instance: back-to-back write then read
        sel = 0;
        fill_ram();
        step(T_NSEQ, 1'b1, 1'b0, 32'h10, 3'd2, 32'hDEAD_BEEF);
        step(T_NSEQ, 1'b0, 1'b0, 32'h10, 3'd2, 32'd0);
        idle_step();
        excl_plan();

        // two-wait instance: byte write, errors, last word
        sel = 1;
        fill_ram();
        step(T_NSEQ, 1'b1, 1'b0, 32'h10, 3'd2, 32'hDEAD_BEEF);
        step(T_NSEQ, 1'b1, 1'b0, 32'h13, 3'd0, {8'hAB, 24'($urandom)});
        step(T_NSEQ, 1'b0, 1'b0, 32'h10, 3'd2, 32'd0);
        step(T_NSEQ, 1'b0, 1'b0, 32'h400, 3'd2, 32'd0);
        step(T_NSEQ, 1'b0, 1'b0, 32'h11, 3'd1, 32'd0);
        step(T_NSEQ, 1'b1, 1'b0, 32'h400, 3'd2, 32'h0BAD_0BAD);
        step(T_NSEQ, 1'b1, 1'b0, 32'h12, 3'd2, 32'h0BAD_0BAD);
        step(T_NSEQ, 1'b1, 1'b0, 32'h10, 3'd3, 32'h0BAD_0BAD);
        step(T_NSEQ, 1'b0, 1'b0, 32'h10, 3'd2, 32'd0);
        step(T_NSEQ, 1'b1, 1'b0, 32'h3FC, 3'd2, 32'h5EED_F00D);
        step(T_NSEQ, 1'b1, 1'b0, 32'h3FE, 3'd1, 32'hA5A5_0000);
        step(T_NSEQ, 1'b0, 1'b0, 32'h3FC, 3'd2, 32'd0);
        idle_step();
        excl_plan();

        // reset during the wait state of a write abandons it and drops the reservation
        step(T_NSEQ, 1'b0, 1'b1, 32'h30, 3'd2, 32'd0);
        step(T_NSEQ, 1'b1, 1'b0, 32'h30, 3'd2, 32'h55AA_1234);
        chk("pre_rst_wait", 32'(rdy_o), 32'd0);
        htrans = T_IDLE;
        #1 rst = 1'b1;
        #1 chk_rst_outs("rst_mid");
        @(posedge clk); #1;
        chk_rst_outs("rst_hold");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        pend_v = 1'b0;
        rv = '{1'b0, 1'b0};
        step(T_NSEQ, 1'b0, 1'b0, 32'h30, 3'd2, 32'd0);
        step(T_NSEQ, 1'b1, 1'b1, 32'h30, 3'd2, 32'h9999_9999);
        step(T_NSEQ, 1'b0, 1'b0, 32'h30, 3'd2, 32'd0);
        idle_step();

        sel = 0;
        rand_run(200);
        sel = 1;
        rand_run(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
